// File: rtl/fetch_ctrl.sv
// Dual-issue instruction fetch front end: pulls up to two instructions per cycle
// from a two-port instruction memory into a circular queue drained by decode.
module fetch_ctrl #(
  parameter int unsigned   DEPTH  = 4,
  parameter int unsigned   AW     = 5,
  parameter logic [AW-1:0] PC_RST = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] dir,
  output logic [AW-1:0] dir2,
  input  logic [31:0]   ins,
  input  logic [31:0]   ins2,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic [1:0]    deq,
  output logic [31:0]   out_ins0,
  output logic [31:0]   out_ins1,
  output logic [AW-1:0] out_pc0,
  output logic [AW-1:0] out_pc1,
  output logic [2:0]    avail
);

  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic [31:0]   q_ins [DEPTH];
  logic [AW-1:0] q_pc  [DEPTH];

  logic [CW-1:0] space, count_nxt;
  logic [1:0]    enq, pop, deq_eff;
  logic [PW-1:0] head1, tail1;

  // Pointer arithmetic modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    int unsigned s;
    s = 32'(p) + 32'(n);
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  assign dir  = pc;
  assign dir2 = pc + AW'(1);

  always_comb begin
    space     = CW'(DEPTH) - count;
    enq       = (space >= CW'(2)) ? 2'd2 : space[1:0];
    deq_eff   = (deq == 2'd3) ? 2'd2 : deq;
    pop       = (CW'(deq_eff) > count) ? count[1:0] : deq_eff;
    count_nxt = count + CW'(enq) - CW'(pop);
    head1     = ptr_add(head, 2'd1);
    tail1     = ptr_add(tail, 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= PC_RST;
      count <= '0;
      head  <= '0;
      tail  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_ins[i] <= '0;
        q_pc[i]  <= '0;
      end
    end else if (redirect) begin
      pc    <= redirect_pc;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      pc    <= pc + AW'(enq);
      count <= count_nxt;
      head  <= ptr_add(head, pop);
      tail  <= ptr_add(tail, enq);
      if (enq != 2'd0) begin
        q_ins[tail] <= ins;
        q_pc[tail]  <= dir;
      end
      if (enq == 2'd2) begin
        q_ins[tail1] <= ins2;
        q_pc[tail1]  <= dir2;
      end
    end
  end

  always_comb begin
    out_ins0 = '0;
    out_pc0  = '0;
    out_ins1 = '0;
    out_pc1  = '0;
    if (count >= CW'(1)) begin
      out_ins0 = q_ins[head];
      out_pc0  = q_pc[head];
    end
    if (count >= CW'(2)) begin
      out_ins1 = q_ins[head1];
      out_pc1  = q_pc[head1];
    end
    avail = 3'(count);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based reference model,
// with directed fill / stream / redirect / wrap / odd-space / reset sequences.
module tb_fetch_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] i;
    logic [4:0]  p;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  dir, dir2;
  logic [31:0] ins, ins2;
  logic        redirect = 1'b0;
  logic [4:0]  redirect_pc = '0;
  logic [1:0]  deq = '0;
  logic [31:0] out_ins0, out_ins1;
  logic [4:0]  out_pc0, out_pc1;
  logic [2:0]  avail;

  logic [31:0] mem [32];
  ent_t        mq [$];
  logic [4:0]  mpc;
  int          total = 0;
  int          bad = 0;

  assign ins  = mem[dir];
  assign ins2 = mem[dir2];

  always #5 clk = ~clk;

  fetch_ctrl #(.DEPTH(4), .AW(5), .PC_RST(5'd0)) dut (
    .clk(clk), .reset(reset), .dir(dir), .dir2(dir2), .ins(ins), .ins2(ins2),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .out_ins0(out_ins0), .out_ins1(out_ins1), .out_pc0(out_pc0), .out_pc1(out_pc1),
    .avail(avail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit rd, input logic [4:0] rpc, input logic [1:0] d);
    int sz, ne, np;
    ent_t e;
    if (r) begin
      mq.delete();
      mpc = 5'd0;
    end else if (rd) begin
      mq.delete();
      mpc = rpc;
    end else begin
      sz = mq.size();
      ne = (DEPTH - sz < 2) ? DEPTH - sz : 2;
      np = (d == 2'd3) ? 2 : int'(d);
      if (np > sz) np = sz;
      repeat (np) void'(mq.pop_front());
      repeat (ne) begin
        e.i = mem[mpc];
        e.p = mpc;
        mq.push_back(e);
        mpc = mpc + 5'd1;
      end
    end
  endtask

  task automatic check_all();
    check("avail", 32'(avail), 32'(mq.size()));
    check("ins0", out_ins0, (mq.size() >= 1) ? mq[0].i : 32'h0);
    check("pc0", 32'(out_pc0), (mq.size() >= 1) ? 32'(mq[0].p) : 32'h0);
    check("ins1", out_ins1, (mq.size() >= 2) ? mq[1].i : 32'h0);
    check("pc1", 32'(out_pc1), (mq.size() >= 2) ? 32'(mq[1].p) : 32'h0);
    check("dir", 32'(dir), 32'(mpc));
    check("dir2", 32'(dir2), 32'(5'(mpc + 5'd1)));
  endtask

  task automatic step(input bit r, input bit rd, input logic [4:0] rpc, input logic [1:0] d);
    reset = r;
    redirect = rd;
    redirect_pc = rpc;
    deq = d;
    model_edge(r, rd, rpc, d);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
    mem[0]  = 32'h00221803;
    mem[1]  = 32'h0C850001;
    mem[20] = 32'h10210000;
    mem[31] = 32'h0;
    mpc = 5'd0;

    @(negedge clk);
    step(1, 0, 5'd0, 2'd0);
    check("rst_avail", 32'(avail), 32'd0);
    check("rst_dir2", 32'(dir2), 32'd1);

    // fill
    step(0, 0, 5'd0, 2'd0);
    check("fill_avail1", 32'(avail), 32'd2);
    check("fill_ins0", out_ins0, 32'h00221803);
    check("fill_ins1", out_ins1, 32'h0C850001);
    step(0, 0, 5'd0, 2'd0);
    check("fill_avail2", 32'(avail), 32'd4);
    check("fill_pc", 32'(dir), 32'd4);
    step(0, 0, 5'd0, 2'd0);
    check("hold_pc", 32'(dir), 32'd4);

    // streaming
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 5'd0, 2'd2);
      check("stream_pc0", 32'(out_pc0), 32'(2 * k));
      check("stream_avail", 32'(avail), (k == 1) ? 32'd4 - 32'd2 : 32'd2);
    end
    step(0, 0, 5'd0, 2'd0);
    check("pre_redir_avail", 32'(avail), 32'd4);

    // redirect
    step(0, 1, 5'h14, 2'd2);
    check("redir_avail", 32'(avail), 32'd0);
    check("redir_dir", 32'(dir), 32'h14);
    step(0, 0, 5'd0, 2'd0);
    check("redir_ins0", out_ins0, 32'h10210000);
    check("redir_pc0", 32'(out_pc0), 32'h14);

    // wrap
    step(0, 1, 5'h1F, 2'd0);
    step(0, 0, 5'd0, 2'd0);
    check("wrap_pc0", 32'(out_pc0), 32'h1F);
    check("wrap_ins0", out_ins0, 32'h0);
    check("wrap_pc1", 32'(out_pc1), 32'h0);
    check("wrap_ins1", out_ins1, 32'h00221803);
    check("wrap_dir", 32'(dir), 32'h01);

    // odd space
    step(0, 0, 5'd0, 2'd1);
    check("odd_avail3", 32'(avail), 32'd3);
    step(0, 0, 5'd0, 2'd0);
    check("odd_avail4", 32'(avail), 32'd4);
    check("odd_dir", 32'(dir), 32'd4);
    step(0, 0, 5'd0, 2'd3);
    check("odd_deq3", 32'(avail), 32'd2);

    // reset during operation, then held
    step(0, 0, 5'd0, 2'd1);
    check("pre_rst_avail", 32'(avail), 32'd3);
    step(1, 1, 5'h0A, 2'd2);
    check("oprst_avail", 32'(avail), 32'd0);
    check("oprst_ins0", out_ins0, 32'h0);
    check("oprst_dir", 32'(dir), 32'd0);
    step(1, 0, 5'd0, 2'd0);
    step(1, 0, 5'd0, 2'd0);
    step(0, 0, 5'd0, 2'd0);
    check("resume_pc0", 32'(out_pc0), 32'd0);
    check("resume_avail", 32'(avail), 32'd2);

    // random
    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
           5'($urandom), 2'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
